// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file write path.
//   REG_ADDR_W / XLEN : register index and data widths
//   REG_ZERO          : architectural zero register (never written)
//   lu_entry_t        : one buffered long-latency result {rd, data}
//   wr_src_e          : which source owns the register-file write port this cycle
package regfile_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned XLEN       = 32;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } lu_entry_t;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_WB,
        SRC_LU
    } wr_src_e;

endpackage

// File: rtl/lu_result_fifo.sv
// Synchronous FIFO holding long-latency results until a write slot is free.
//   clk, rst_n  : clock, synchronous active-low reset (empties the FIFO)
//   push        : store push_entry (ignored when full)
//   push_entry  : {rd, data} to store
//   pop         : discard the head entry (ignored when empty)
//   head        : oldest stored entry
//   full, empty : occupancy flags
//   count       : occupancy, 0..DEPTH
module lu_result_fifo
    import regfile_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  lu_entry_t                push_entry,
    input  logic                     pop,
    output lu_entry_t                head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    lu_entry_t       mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            push_ok;
    logic            pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign head    = mem[rd_ptr];

    // Storage is not reset; the pointers and count alone define validity.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Arbitrates the single register-file write port between the in-order
// writeback path and out-of-band long-latency (mul/div) results.
//   clk, rst_n      : clock, synchronous active-low reset
//   wb_rd/wb_data/wb_reg_write : pipeline writeback request
//   wb_stall        : pipeline must hold wb_* this cycle (starvation relief)
//   lu_valid/lu_rd/lu_data     : long-latency result offer
//   lu_ready        : result accepted this cycle when lu_valid is high
//   rf_rd_addr/rf_rd_data/rf_rd_we : registered register-file write port
//   lu_pending      : number of buffered long-latency results
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int unsigned DEPTH        = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [REG_ADDR_W-1:0]    wb_rd,
    input  logic [XLEN-1:0]          wb_data,
    input  logic                     wb_reg_write,
    output logic                     wb_stall,
    input  logic                     lu_valid,
    input  logic [REG_ADDR_W-1:0]    lu_rd,
    input  logic [XLEN-1:0]          lu_data,
    output logic                     lu_ready,
    output logic [REG_ADDR_W-1:0]    rf_rd_addr,
    output logic [XLEN-1:0]          rf_rd_data,
    output logic                     rf_rd_we,
    output logic [$clog2(DEPTH):0]   lu_pending
);

    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    lu_entry_t      fifo_head;
    lu_entry_t      push_entry;
    logic           fifo_full;
    logic           fifo_empty;
    logic           fifo_push;
    logic           drain;
    logic           pv;
    wr_src_e        sel;
    logic [SW-1:0]  starve_cnt;

    assign pv       = wb_reg_write & (wb_rd != REG_ZERO);
    assign lu_ready = ~fifo_full;

    // Results to x0 complete the handshake but are dropped here.
    assign fifo_push  = lu_valid & lu_ready & (lu_rd != REG_ZERO);
    assign push_entry = '{rd: lu_rd, data: lu_data};

    assign wb_stall = (starve_cnt == STARVE_MAX) & ~fifo_empty;

    always_comb begin
        sel = SRC_NONE;
        if (wb_stall) begin
            sel = SRC_LU;
        end else if (pv) begin
            sel = SRC_WB;
        end else if (!fifo_empty) begin
            sel = SRC_LU;
        end
    end

    assign drain = (sel == SRC_LU);

    lu_result_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (fifo_push),
        .push_entry (push_entry),
        .pop        (drain),
        .head       (fifo_head),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .count      (lu_pending)
    );

    // Idle slots hold the last address/data and only drop the enable.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rf_rd_addr <= '0;
            rf_rd_data <= '0;
            rf_rd_we   <= 1'b0;
        end else begin
            case (sel)
                SRC_WB: begin
                    rf_rd_addr <= wb_rd;
                    rf_rd_data <= wb_data;
                    rf_rd_we   <= 1'b1;
                end
                SRC_LU: begin
                    rf_rd_addr <= fifo_head.rd;
                    rf_rd_data <= fifo_head.data;
                    rf_rd_we   <= (fifo_head.rd != REG_ZERO);
                end
                default: begin
                    rf_rd_we   <= 1'b0;
                end
            endcase
        end
    end

    // Counts cycles a buffered result waits behind pipeline writes; saturating.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (fifo_empty || drain) begin
            starve_cnt <= '0;
        end else if (starve_cnt != STARVE_MAX) begin
            starve_cnt <= starve_cnt + SW'(1);
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed self-checking bench for regfile_write_arbiter (DEPTH=2, STARVE_LIMIT=4).
module tb_regfile_write_arbiter;

    logic        clk;
    logic        rst_n;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_reg_write;
    logic        wb_stall;
    logic        lu_valid;
    logic [4:0]  lu_rd;
    logic [31:0] lu_data;
    logic        lu_ready;
    logic [4:0]  rf_rd_addr;
    logic [31:0] rf_rd_data;
    logic        rf_rd_we;
    logic [1:0]  lu_pending;

    int unsigned checks;
    int unsigned failures;

    regfile_write_arbiter #(
        .DEPTH        (2),
        .STARVE_LIMIT (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .wb_reg_write (wb_reg_write),
        .wb_stall     (wb_stall),
        .lu_valid     (lu_valid),
        .lu_rd        (lu_rd),
        .lu_data      (lu_data),
        .lu_ready     (lu_ready),
        .rf_rd_addr   (rf_rd_addr),
        .rf_rd_data   (rf_rd_data),
        .rf_rd_we     (rf_rd_we),
        .lu_pending   (lu_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_rf(input string tag, input logic we, input logic [4:0] addr,
                            input logic [31:0] data);
        check({tag, ".we"},   64'(rf_rd_we),   64'(we));
        check({tag, ".addr"}, 64'(rf_rd_addr), 64'(addr));
        check({tag, ".data"}, 64'(rf_rd_data), 64'(data));
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        rst_n        = 1'b0;
        wb_rd        = '0;
        wb_data      = '0;
        wb_reg_write = 1'b0;
        lu_valid     = 1'b0;
        lu_rd        = '0;
        lu_data      = '0;

        // Reset then idle.
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("idle.we",      64'(rf_rd_we),   64'd0);
            check("idle.ready",   64'(lu_ready),   64'd1);
            check("idle.pending", 64'(lu_pending), 64'd0);
            check("idle.stall",   64'(wb_stall),   64'd0);
        end
        check_rf("idle.rf", 1'b0, 5'd0, 32'd0);

        // Pipeline only, then the same write aimed at x0.
        wb_rd = 5'd5; wb_data = 32'hDEADBEEF; wb_reg_write = 1'b1;
        step();
        check_rf("wb.x5", 1'b1, 5'd5, 32'hDEADBEEF);
        wb_rd = 5'd0;
        step();
        check_rf("wb.x0", 1'b0, 5'd5, 32'hDEADBEEF);
        wb_reg_write = 1'b0;
        step();

        // LU result drains through an idle slot.
        lu_valid = 1'b1; lu_rd = 5'd7; lu_data = 32'h12345678;
        check("lu.ready", 64'(lu_ready), 64'd1);
        step();
        lu_valid = 1'b0;
        check("lu.pending1", 64'(lu_pending), 64'd1);
        check("lu.we_wait",  64'(rf_rd_we),   64'd0);
        step();
        check("lu.pending0", 64'(lu_pending), 64'd0);
        check_rf("lu.x7", 1'b1, 5'd7, 32'h12345678);

        // LU result for x0 is accepted but never stored.
        lu_valid = 1'b1; lu_rd = 5'd0; lu_data = 32'hFFFF0000;
        step();
        lu_valid = 1'b0;
        check("lu0.pending", 64'(lu_pending), 64'd0);
        step();
        check("lu0.we", 64'(rf_rd_we), 64'd0);

        // Full FIFO under continuous pipeline writes; third result must wait.
        wb_rd = 5'd10; wb_data = 32'hAAAA0000; wb_reg_write = 1'b1;
        lu_valid = 1'b1; lu_rd = 5'd1; lu_data = 32'h111;
        step();
        check("full.p1", 64'(lu_pending), 64'd1);
        check_rf("full.wb1", 1'b1, 5'd10, 32'hAAAA0000);
        lu_rd = 5'd2; lu_data = 32'h222;
        step();
        check("full.p2",    64'(lu_pending), 64'd2);
        check("full.ready", 64'(lu_ready),   64'd0);
        check("full.stall", 64'(wb_stall),   64'd0);
        lu_rd = 5'd4; lu_data = 32'h444;
        step();
        check("full.held3", 64'(lu_ready), 64'd0);
        check("full.st3",   64'(wb_stall), 64'd0);
        step();
        check("full.held4", 64'(lu_ready), 64'd0);
        check("full.st4",   64'(wb_stall), 64'd0);
        step();
        check("full.st5", 64'(wb_stall), 64'd1);
        check_rf("full.wb5", 1'b1, 5'd10, 32'hAAAA0000);
        step();
        check("full.st6",    64'(wb_stall),   64'd0);
        check("full.p6",     64'(lu_pending), 64'd1);
        check("full.ready6", 64'(lu_ready),   64'd1);
        check_rf("full.x1", 1'b1, 5'd1, 32'h111);
        step();
        lu_valid = 1'b0; wb_reg_write = 1'b0;
        check("full.p7", 64'(lu_pending), 64'd2);
        check_rf("full.wb7", 1'b1, 5'd10, 32'hAAAA0000);
        step();
        check_rf("full.x2", 1'b1, 5'd2, 32'h222);
        check("full.p8", 64'(lu_pending), 64'd1);
        step();
        check_rf("full.x4", 1'b1, 5'd4, 32'h444);
        check("full.p9", 64'(lu_pending), 64'd0);
        step();
        check("full.we10", 64'(rf_rd_we), 64'd0);

        // Starvation: x9 waits four pipeline writes, then one forced stall.
        lu_valid = 1'b1; lu_rd = 5'd9; lu_data = 32'h99;
        step();
        lu_valid = 1'b0;
        wb_rd = 5'd3; wb_data = 32'h33333333; wb_reg_write = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            step();
            check("starve.nostall", 64'(wb_stall), 64'd0);
            check_rf("starve.wb", 1'b1, 5'd3, 32'h33333333);
        end
        step();
        check("starve.stall", 64'(wb_stall), 64'd1);
        check_rf("starve.wb4", 1'b1, 5'd3, 32'h33333333);
        step();
        check("starve.release", 64'(wb_stall),   64'd0);
        check("starve.pending", 64'(lu_pending), 64'd0);
        check_rf("starve.x9", 1'b1, 5'd9, 32'h99);
        step();
        check_rf("starve.held", 1'b1, 5'd3, 32'h33333333);
        wb_reg_write = 1'b0;

        // Reset mid-operation discards buffered results.
        wb_rd = 5'd6; wb_data = 32'h66; wb_reg_write = 1'b1;
        lu_valid = 1'b1; lu_rd = 5'd11; lu_data = 32'hB;
        step();
        lu_rd = 5'd12; lu_data = 32'hC;
        step();
        check("rst.filled", 64'(lu_pending), 64'd2);
        lu_valid = 1'b0; wb_reg_write = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("rst.pending", 64'(lu_pending), 64'd0);
        check("rst.stall",   64'(wb_stall),   64'd0);
        check("rst.ready",   64'(lu_ready),   64'd1);
        check_rf("rst.rf", 1'b0, 5'd0, 32'd0);
        for (int i = 0; i < 6; i++) begin
            step();
            check("rst.after_we",      64'(rf_rd_we),   64'd0);
            check("rst.after_pending", 64'(lu_pending), 64'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
